// File: rtl/lfsr_run_ctrl_if.sv
// Control/status and LFSR-side signal bundle for lfsr_run_ctrl.
// The master side is the register block plus the LFSR; the slave side is the sequencer.
interface lfsr_run_ctrl_if #(
    parameter int LEN_W = 22
);
    // Handshake: start is sampled only while idle (busy=0). busy stays high through
    // the load and run phases. done is a single-cycle pulse after a completed run.
    // An aborted run returns to idle with no done pulse.
    logic             start;
    logic             abort;
    logic [LEN_W-1:0] run_len;
    logic             lfsr_cycle;
    logic             lfsr_load;
    logic             lfsr_sam_clk_en;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] sample_cnt;
    logic             period_err;
    logic [1:0]       dbg_state;

    modport master (
        output start, abort, run_len, lfsr_cycle,
        input  lfsr_load, lfsr_sam_clk_en, busy, done, sample_cnt, period_err, dbg_state
    );

    modport slave (
        input  start, abort, run_len, lfsr_cycle,
        output lfsr_load, lfsr_sam_clk_en, busy, done, sample_cnt, period_err, dbg_state
    );
endinterface

// File: rtl/lfsr_run_ctrl.sv
// Sequencer for a sample-rate LFSR: divider enable, seed load, counted or full-period run.
// Optional period check and runaway guard: define LFSR_RUN_CTRL_PERIOD_CHECK_EN.
module lfsr_run_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int LEN_W   = 22
) (
    input  logic              sys_clk,
    input  logic              reset,
    lfsr_run_ctrl_if.slave    bus
);
    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [LEN_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div_cnt;
    logic [LEN_W-1:0] r_len_q;
    logic [LEN_W-1:0] r_sample_cnt;

    logic             w_div_wrap;
    logic             w_en;
    logic [LEN_W-1:0] w_cnt_inc;
    logic             w_len_zero;

    assign w_div_wrap = (r_div_cnt == DIV_LAST);
    assign w_en       = (r_state == S_RUN) && w_div_wrap;
    assign w_cnt_inc  = r_sample_cnt + LEN_W'(1);
    assign w_len_zero = (r_len_q == '0);

`ifdef LFSR_RUN_CTRL_PERIOD_CHECK_EN
    logic r_period_err;
    assign bus.period_err = r_period_err;
`else
    assign bus.period_err = 1'b0;
`endif

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_div_cnt    <= '0;
            r_len_q      <= '0;
            r_sample_cnt <= '0;
`ifdef LFSR_RUN_CTRL_PERIOD_CHECK_EN
            r_period_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        r_state      <= S_LOAD;
                        r_len_q      <= bus.run_len;
                        r_sample_cnt <= '0;
`ifdef LFSR_RUN_CTRL_PERIOD_CHECK_EN
                        r_period_err <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    r_div_cnt <= '0;
                    r_state   <= bus.abort ? S_IDLE : S_RUN;
                end
                S_RUN: begin
                    r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + DIV_W'(1);
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                    end else if (w_len_zero && bus.lfsr_cycle) begin
                        r_state <= S_DONE;
`ifdef LFSR_RUN_CTRL_PERIOD_CHECK_EN
                        r_period_err <= (r_sample_cnt != CNT_MAX);
`endif
                    end else if (w_en) begin
                        // Saturate rather than wrap so a runaway run stays visible.
                        if (r_sample_cnt != CNT_MAX) r_sample_cnt <= w_cnt_inc;
                        if (!w_len_zero && (w_cnt_inc == r_len_q)) begin
                            r_state <= S_DONE;
                        end
`ifdef LFSR_RUN_CTRL_PERIOD_CHECK_EN
                        else if (w_len_zero && (r_sample_cnt == CNT_MAX)) begin
                            r_state      <= S_DONE;
                            r_period_err <= 1'b1;
                        end
`endif
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.lfsr_load       = (r_state == S_LOAD);
    assign bus.lfsr_sam_clk_en = w_en;
    assign bus.busy            = (r_state == S_LOAD) || (r_state == S_RUN);
    assign bus.done            = (r_state == S_DONE);
    assign bus.sample_cnt      = r_sample_cnt;
    assign bus.dbg_state       = r_state;
endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// Directed bench for lfsr_run_ctrl: a 22-bit and a 4-bit instance, both with CLK_DIV=4.
module tb_lfsr_run_ctrl;
    logic sys_clk = 1'b0;
    logic reset   = 1'b1;
    int   errors  = 0;
    int   checks  = 0;

    always #5 sys_clk = ~sys_clk;

    lfsr_run_ctrl_if #(.LEN_W(22)) bw ();
    lfsr_run_ctrl_if #(.LEN_W(4))  bn ();

    lfsr_run_ctrl #(.CLK_DIV(4), .LEN_W(22)) u_dut_w (.sys_clk(sys_clk), .reset(reset), .bus(bw));
    lfsr_run_ctrl #(.CLK_DIV(4), .LEN_W(4))  u_dut_n (.sys_clk(sys_clk), .reset(reset), .bus(bn));

`ifdef LFSR_RUN_CTRL_PERIOD_CHECK_EN
    localparam logic EXP_SHORT_ERR = 1'b1;
`else
    localparam logic EXP_SHORT_ERR = 1'b0;
`endif

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int  n;
    int  loads;
    int  ens;
    int  dones;
    bit  found;
    bit  inj;
    bit  seen_done;

    initial begin
        #200000;
        $display("FAIL timeout: observed=hung expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        bw.start = 0; bw.abort = 0; bw.run_len = '0; bw.lfsr_cycle = 0;
        bn.start = 0; bn.abort = 0; bn.run_len = '0; bn.lfsr_cycle = 0;

        // Reset state
        step(); step();
        chk("rst_w_state", 32'(bw.dbg_state), 0);
        chk("rst_w_outs", {bw.lfsr_load, bw.lfsr_sam_clk_en, bw.busy, bw.done, bw.period_err}, 0);
        chk("rst_w_cnt", 32'(bw.sample_cnt), 0);
        chk("rst_n_outs", {bn.lfsr_load, bn.lfsr_sam_clk_en, bn.busy, bn.done, bn.period_err}, 0);
        chk("rst_n_cnt", 32'(bn.sample_cnt), 0);
        reset = 0;
        step();

        // 1: reset mid-run clears asynchronously; nothing issued afterwards
        bw.run_len = 22'd100; bw.start = 1;
        step();
        bw.start = 0;
        repeat (10) step();
        chk("t1_busy_before", 32'(bw.busy), 1);
        #2 reset = 1;
        #1;
        chk("t1_async_outs", {bw.lfsr_load, bw.lfsr_sam_clk_en, bw.busy, bw.done}, 0);
        chk("t1_async_cnt", 32'(bw.sample_cnt), 0);
        chk("t1_async_state", 32'(bw.dbg_state), 0);
        step(); step();
        reset = 0;
        ens = 0; loads = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (bw.lfsr_sam_clk_en) ens++;
            if (bw.lfsr_load) loads++;
        end
        chk("t1_no_en", 32'(ens), 0);
        chk("t1_no_load", 32'(loads), 0);

        // 2: counted run of 5, cycle-exact timing
        bw.run_len = 22'd5; bw.start = 1;
        step();
        bw.start = 0;
        chk("t2_load", 32'(bw.lfsr_load), 1);
        chk("t2_busy_load", 32'(bw.busy), 1);
        for (int k = 2; k <= 22; k++) begin
            step();
            chk($sformatf("t2_en_k%0d", k), 32'(bw.lfsr_sam_clk_en),
                32'((k >= 5) && (k <= 21) && ((k - 1) % 4 == 0)));
            chk($sformatf("t2_busy_k%0d", k), 32'(bw.busy), 32'(k <= 21));
            chk($sformatf("t2_done_k%0d", k), 32'(bw.done), 32'(k == 22));
        end
        chk("t2_cnt", 32'(bw.sample_cnt), 5);
        chk("t2_perr", 32'(bw.period_err), 0);
        step();
        chk("t2_done_gone", 32'(bw.done), 0);
        chk("t2_cnt_hold", 32'(bw.sample_cnt), 5);

        // 3: full-period run on 4-bit instance, cycle after 15th enable
        bn.run_len = 4'd0; bn.start = 1;
        step();
        bn.start = 0;
        n = 0; found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            step();
            if (bn.lfsr_sam_clk_en) n++;
            if (n == 15) found = 1;
        end
        chk("t3_found15", 32'(found), 1);
        step();
        bn.lfsr_cycle = 1;
        step();
        bn.lfsr_cycle = 0;
        chk("t3_done", 32'(bn.done), 1);
        chk("t3_cnt", 32'(bn.sample_cnt), 15);
        chk("t3_perr", 32'(bn.period_err), 0);
        step();
        chk("t3_idle", 32'(bn.dbg_state), 0);

        // 4: short period, cycle after 14th enable
        bn.start = 1;
        step();
        bn.start = 0;
        n = 0; found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            step();
            if (bn.lfsr_sam_clk_en) n++;
            if (n == 14) found = 1;
        end
        chk("t4_found14", 32'(found), 1);
        step();
        bn.lfsr_cycle = 1;
        step();
        bn.lfsr_cycle = 0;
        chk("t4_done", 32'(bn.done), 1);
        chk("t4_cnt", 32'(bn.sample_cnt), 14);
        chk("t4_perr", 32'(bn.period_err), 32'(EXP_SHORT_ERR));
        step();
        chk("t4_perr_hold", 32'(bn.period_err), 32'(EXP_SHORT_ERR));
        chk("t4_done_gone", 32'(bn.done), 0);

        // 5: abort two cycles after the third enable
        bw.run_len = 22'd10; bw.start = 1;
        step();
        bw.start = 0;
        n = 0; found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            step();
            if (bw.lfsr_sam_clk_en) n++;
            if (n == 3) found = 1;
        end
        chk("t5_found3", 32'(found), 1);
        step(); step();
        bw.abort = 1;
        step();
        bw.abort = 0;
        chk("t5_idle", 32'(bw.dbg_state), 0);
        chk("t5_busy", 32'(bw.busy), 0);
        chk("t5_done", 32'(bw.done), 0);
        chk("t5_cnt", 32'(bw.sample_cnt), 3);
        ens = 0; dones = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bw.lfsr_sam_clk_en) ens++;
            if (bw.done) dones++;
        end
        chk("t5_no_en", 32'(ens), 0);
        chk("t5_no_done", 32'(dones), 0);
        chk("t5_cnt_hold", 32'(bw.sample_cnt), 3);

        // 6a: start together with abort in idle
        bw.start = 1; bw.abort = 1;
        step();
        bw.start = 0; bw.abort = 0;
        chk("t6_no_load", 32'(bw.lfsr_load), 0);
        chk("t6_still_idle", 32'(bw.dbg_state), 0);

        // 6b: start and lfsr_cycle during a counted run are ignored
        bw.run_len = 22'd8; bw.start = 1;
        step();
        bw.start = 0;
        n = 0; loads = 0; inj = 0; seen_done = 0;
        for (int c = 0; c < 100 && !seen_done; c++) begin
            step();
            bw.start = 0; bw.lfsr_cycle = 0;
            if (bw.lfsr_sam_clk_en) n++;
            if (bw.lfsr_load) loads++;
            if (bw.done) seen_done = 1;
            if (n == 2 && !inj) begin
                inj = 1; bw.start = 1; bw.run_len = 22'd3; bw.lfsr_cycle = 1;
            end
        end
        chk("t6_done", 32'(seen_done), 1);
        chk("t6_en_count", 32'(n), 8);
        chk("t6_cnt", 32'(bw.sample_cnt), 8);
        chk("t6_no_reload", 32'(loads), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
